// File: rtl/bp_pkg.sv
// bp_pkg: shared types and constants for the BTB/BHT branch predictor.
package bp_pkg;
    typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} bp_ctr_t;
    // Tag field sized for the smallest index width; narrower tags are stored zero-extended.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
        bp_ctr_t     ctr;
    } bp_entry_t;
    localparam bp_ctr_t CTR_RESET = WNT;
    localparam bp_ctr_t CTR_ALLOC = WT;
endpackage

// File: rtl/module_branch_predictor_sat_counter2.sv
// module_sat_counter2: next state of a 2-bit saturating taken/not-taken counter.
module module_sat_counter2
    import bp_pkg::*;
(
    input  bp_ctr_t ctr,
    input  logic    taken,
    output bp_ctr_t ctr_next
);
    always_comb begin
        ctr_next = taken ? ((ctr == ST) ? ST : bp_ctr_t'(ctr + 2'd1))
                         : ((ctr == SNT) ? SNT : bp_ctr_t'(ctr - 2'd1));
    end
endmodule

// File: rtl/module_branch_predictor.sv
// module_branch_predictor: direct-mapped BTB + 2-bit BHT, predicts in fetch, updates from execute.
// Define BP_PERF_COUNTERS_EN to add saturating branch/mispredict counters.
module module_branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        BranchE,
    input  logic        takenE,
    input  logic [31:0] PCE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] PCPlus4E,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    output logic        MispredictE,
    output logic [31:0] CorrectPCE
`ifdef BP_PERF_COUNTERS_EN
    ,
    output logic [31:0] BranchCount,
    output logic [31:0] MispredCount
`endif
);
    localparam int TAG_BITS = 30 - IDX_BITS;
    localparam int N = 2 ** IDX_BITS;

    bp_entry_t tbl [N];
    bp_entry_t ent_f, ent_e;
    bp_ctr_t ctr_next;
    logic [IDX_BITS-1:0] idx_f, idx_e;
    logic [29:0] tag_f, tag_e;
    logic hit_e;
    logic unused_lsbs;

    assign unused_lsbs = &{1'b0, PCF[1:0], PCE[1:0]};
    assign idx_f = PCF[IDX_BITS+1:2];
    assign idx_e = PCE[IDX_BITS+1:2];
    assign tag_f = 30'(PCF[31:IDX_BITS+2]);
    assign tag_e = 30'(PCE[31:IDX_BITS+2]);
    assign ent_f = tbl[idx_f];
    assign ent_e = tbl[idx_e];
    assign hit_e = ent_e.valid && (ent_e.tag == tag_e);

    assign PredTakenF = ent_f.valid && (ent_f.tag == tag_f) && ent_f.ctr[1];
    assign PredTargetF = PredTakenF ? ent_f.target : 32'h0;
    assign MispredictE = BranchE && ((takenE != PredTakenE) ||
                         (takenE && PredTakenE && (PredTargetE != PCTargetE)));
    assign CorrectPCE = takenE ? PCTargetE : PCPlus4E;

    module_sat_counter2 u_ctr (.ctr(ent_e.ctr), .taken(takenE), .ctr_next(ctr_next));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
        end else if (BranchE) begin
            if (hit_e) begin
                tbl[idx_e].ctr <= ctr_next;
                if (takenE) tbl[idx_e].target <= PCTargetE;
            end else if (takenE) begin
                tbl[idx_e] <= '{valid: 1'b1, tag: tag_e, target: PCTargetE, ctr: CTR_ALLOC};
            end
        end
    end

`ifdef BP_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            BranchCount <= '0;
            MispredCount <= '0;
        end else begin
            if (BranchE && BranchCount != 32'hFFFF_FFFF) BranchCount <= BranchCount + 32'd1;
            if (MispredictE && MispredCount != 32'hFFFF_FFFF) MispredCount <= MispredCount + 32'd1;
        end
    end
`endif
endmodule
